// File: rtl/vid_stream_pkg.sv
// Shared types and constants for the video stream framer: FSM states, RGB packing, error bits.
package vid_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } vsf_state_e;

    localparam int RGB_W     = 24;
    localparam int RGB_R_LSB = 16;
    localparam int RGB_G_LSB = 8;
    localparam int RGB_B_LSB = 0;

    localparam int ERR_W           = 3;
    localparam int ERR_SHORT_FRAME = 0;
    localparam int ERR_EXTRA       = 1;
    localparam int ERR_SHORT_LINE  = 2;

    // Test pattern: r = x, g = y, b = x ^ y (low 8 bits of the coordinates).
    function automatic logic [RGB_W-1:0] tpg_pixel(input logic [7:0] x, input logic [7:0] y);
        logic [RGB_W-1:0] p;
        p = '0;
        p[RGB_R_LSB +: 8] = x;
        p[RGB_G_LSB +: 8] = y;
        p[RGB_B_LSB +: 8] = x ^ y;
        return p;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a level (polarity-normalised) and flags its leading/trailing edges against the previous cycle.
module sync_edge_det #(
    parameter bit ACT_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic lvl,
    output logic lead,
    output logic trail
);

    logic act;

    assign act = ACT_HIGH ? sig : ~sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= 1'b0;
        end else begin
            lvl <= act;
        end
    end

    assign lead  = act & ~lvl;
    assign trail = ~act & lvl;

endmodule

// File: rtl/vid_stream_framer.sv
// Converts vs/de/rgb timing into a frame-delimited pixel stream of exactly WIDTH*HEIGHT beats.
// Optional test pattern generator built only when VSF_TPG_EN is defined.
//
// state  | meaning
// IDLE   | after reset, waiting for the first vs leading edge
// SYNC   | inside vertical sync, waiting for its trailing edge
// ACTIVE | counting pixels of the current frame
// DONE   | last beat sent, extra pixels are dropped until next vs
module vid_stream_framer
    import vid_stream_pkg::*;
#(
    parameter int WIDTH  = 1920,
    parameter int HEIGHT = 1080,
    parameter bit VS_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vs,
    input  logic              de,
    input  logic [RGB_W-1:0]  rgb,
    input  logic              tpg_sel,
    input  logic              err_clr,
    output logic              dst_valid,
    output logic [RGB_W-1:0]  dst_data,
    output logic              dst_start,
    output logic              dst_last,
    output logic [15:0]       frame_cnt,
    output logic [ERR_W-1:0]  err_flags
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    vsf_state_e       state_q;
    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic             y_over_q;
    logic             started_q;

    logic             vs_lead;
    logic             vs_trail;
    logic             de_trail;
    logic             vs_lvl_unused;
    logic             de_lvl_unused;
    logic             de_lead_unused;

    logic             at_x_end;
    logic             at_y_end;
    logic             emit;
    logic             pad;
    logic             last_beat;
    logic [ERR_W-1:0] err_set;
    logic [RGB_W-1:0] pix;

    sync_edge_det #(.ACT_HIGH(VS_POL)) u_vs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vs),
        .lvl   (vs_lvl_unused),
        .lead  (vs_lead),
        .trail (vs_trail)
    );

    sync_edge_det #(.ACT_HIGH(1'b1)) u_de_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (de),
        .lvl   (de_lvl_unused),
        .lead  (de_lead_unused),
        .trail (de_trail)
    );

`ifdef VSF_TPG_EN
    logic tpg_q;

    // Pattern selection is frozen at the vs leading edge so a frame is never mixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tpg_q <= 1'b0;
        end else if (vs_lead) begin
            tpg_q <= tpg_sel;
        end
    end

    assign pix = tpg_q ? tpg_pixel(8'(x_q), 8'(y_q)) : rgb;
`else
    logic tpg_sel_unused;

    assign tpg_sel_unused = tpg_sel;
    assign pix            = rgb;
`endif

    assign at_x_end  = (x_q == XW'(WIDTH - 1));
    assign at_y_end  = (y_q == YW'(HEIGHT - 1));
    assign last_beat = emit & at_x_end & at_y_end;

    // vs leading edge outranks any pixel presented in the same cycle.
    always_comb begin
        emit    = 1'b0;
        pad     = 1'b0;
        err_set = '0;
        case (state_q)
            ACTIVE: begin
                if (vs_lead) begin
                    pad                      = 1'b1;
                    err_set[ERR_SHORT_FRAME] = 1'b1;
                end else if (de) begin
                    if (y_over_q) begin
                        err_set[ERR_EXTRA] = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end else if (de_trail && (x_q != '0)) begin
                    err_set[ERR_SHORT_LINE] = 1'b1;
                end
            end
            DONE: begin
                if (!vs_lead && de) begin
                    err_set[ERR_EXTRA] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            y_over_q  <= 1'b0;
            started_q <= 1'b0;
            dst_valid <= 1'b0;
            dst_data  <= '0;
            dst_start <= 1'b0;
            dst_last  <= 1'b0;
            frame_cnt <= '0;
            err_flags <= '0;
        end else begin
            dst_valid <= emit | pad;
            dst_data  <= emit ? pix : '0;
            dst_start <= (emit && (x_q == '0) && (y_q == '0)) || (pad && !started_q);
            dst_last  <= last_beat | pad;
            if (last_beat || pad) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            err_flags <= (err_clr ? '0 : err_flags) | err_set;

            case (state_q)
                IDLE: begin
                    if (vs_lead) state_q <= SYNC;
                end
                SYNC: begin
                    if (vs_trail) begin
                        state_q   <= ACTIVE;
                        x_q       <= '0;
                        y_q       <= '0;
                        y_over_q  <= 1'b0;
                        started_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (vs_lead) begin
                        state_q <= SYNC;
                    end else if (emit) begin
                        started_q <= 1'b1;
                        if (at_x_end) begin
                            x_q <= '0;
                            if (at_y_end) begin
                                state_q <= DONE;
                            end else begin
                                y_q <= y_q + 1'b1;
                            end
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end else if (err_set[ERR_SHORT_LINE]) begin
                        // A short final line leaves the frame open; vs will pad it.
                        x_q <= '0;
                        if (at_y_end) begin
                            y_over_q <= 1'b1;
                        end else begin
                            y_q <= y_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (vs_lead) state_q <= SYNC;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid_stream_framer.sv
// Scoreboard bench for vid_stream_framer at WIDTH=8, HEIGHT=4.
module tb_vid_stream_framer;

    localparam int W = 8;
    localparam int H = 4;

    typedef struct {
        logic [23:0] data;
        logic        start;
        logic        last;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0;
    logic        de = 1'b0;
    logic [23:0] rgb = '0;
    logic        tpg_sel = 1'b0;
    logic        err_clr = 1'b0;
    logic        dst_valid;
    logic [23:0] dst_data;
    logic        dst_start;
    logic        dst_last;
    logic [15:0] frame_cnt;
    logic [2:0]  err_flags;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    exp_fc = 0;
    bit    tpg_mode = 1'b0;

    vid_stream_framer #(.WIDTH(W), .HEIGHT(H), .VS_POL(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs        (vs),
        .de        (de),
        .rgb       (rgb),
        .tpg_sel   (tpg_sel),
        .err_clr   (err_clr),
        .dst_valid (dst_valid),
        .dst_data  (dst_data),
        .dst_start (dst_start),
        .dst_last  (dst_last),
        .frame_cnt (frame_cnt),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pix(int x, int y);
        return {8'(16 * y + x), 8'(8'hC0 | x), 8'(8'h3C ^ (x + y))};
    endfunction

    function automatic logic [23:0] exp_data(int x, int y, logic [23:0] rgbv);
`ifdef VSF_TPG_EN
        if (tpg_mode) return {8'(x), 8'(y), 8'(x ^ y)};
`endif
        return rgbv;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [23:0] d, input bit s, input bit l);
        beat_t b;
        b.data  = d;
        b.start = s;
        b.last  = l;
        b.cyc   = cyc + 1;
        sb.push_back(b);
        if (l) exp_fc++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vs = 1'b0; de = 1'b0; rgb = '0;
        end
    endtask

    task automatic vsync(input bit exp_pad, input bit pad_start, input bit de_on_lead);
        @(negedge clk);
        vs = 1'b1; de = de_on_lead; rgb = 24'hABCDEF;
        if (exp_pad) push_beat(24'h0, pad_start, 1'b1);
        @(negedge clk);
        de = 1'b0;
        @(negedge clk);
        vs = 1'b0;
        idle(2);
    endtask

    task automatic send_line(input int y, input int n, input bit expect_beats);
        logic [23:0] v;
        for (int x = 0; x < n; x++) begin
            @(negedge clk);
            v  = tpg_mode ? 24'hFFFFFF : pix(x, y);
            de = 1'b1; rgb = v;
            if (expect_beats)
                push_beat(exp_data(x, y, v), (x == 0) && (y == 0), (x == W - 1) && (y == H - 1));
        end
        idle(3);
    endtask

    task automatic clean_frame_lines();
        for (int y = 0; y < H; y++) send_line(y, W, 1'b1);
    endtask

    // Monitor: every beat the DUT presents must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (dst_valid) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_beat: got data=%06h start=%0b last=%0b, expected no beat",
                         dst_data, dst_start, dst_last);
            end else begin
                e = sb.pop_front();
                if (dst_data !== e.data || dst_start !== e.start || dst_last !== e.last || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL beat: got data=%06h start=%0b last=%0b cyc=%0d, expected data=%06h start=%0b last=%0b cyc=%0d",
                             dst_data, dst_start, dst_last, cyc, e.data, e.start, e.last, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(dst_valid), 32'd0);
        chk("rst_start", 32'(dst_start), 32'd0);
        chk("rst_last",  32'(dst_last),  32'd0);
        chk("rst_data",  32'(dst_data),  32'd0);
        chk("rst_fc",    32'(frame_cnt), 32'd0);
        chk("rst_err",   32'(err_flags), 32'd0);

        // de before any vs is ignored
        send_line(0, W, 1'b0);
        chk("idle_de_err", 32'(err_flags), 32'd0);

        // Frame A: clean
        vsync(1'b0, 1'b0, 1'b0);
        clean_frame_lines();
        chk("A_fc",  32'(frame_cnt), 32'(exp_fc));
        chk("A_err", 32'(err_flags), 32'd0);

        // Frame B: vs after two lines, de coincides with the vs lead -> pad only
        vsync(1'b0, 1'b0, 1'b0);
        send_line(0, W, 1'b1);
        send_line(1, W, 1'b1);
        vsync(1'b1, 1'b0, 1'b1);
        chk("B_err", 32'(err_flags), 32'b001);
        chk("B_fc",  32'(frame_cnt), 32'(exp_fc));

        // Frame C opened by B's vs: must restart at (0,0)
        clean_frame_lines();
        chk("C_fc", 32'(frame_cnt), 32'(exp_fc));
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("C_clr", 32'(err_flags), 32'd0);

        // Frame D: short line 1 -> 29 real beats, last at (7,3)
        vsync(1'b0, 1'b0, 1'b0);
        send_line(0, W, 1'b1);
        send_line(1, 5, 1'b1);
        send_line(2, W, 1'b1);
        send_line(3, W, 1'b1);
        chk("D_err", 32'(err_flags), 32'b100);
        chk("D_fc",  32'(frame_cnt), 32'(exp_fc));
        send_line(0, W, 1'b0);
        chk("D_extra_err", 32'(err_flags), 32'b110);
        @(negedge clk); err_clr = 1'b1; de = 1'b1;
        @(negedge clk); err_clr = 1'b0; de = 1'b0;
        chk("D_clr_vs_event", 32'(err_flags), 32'b010);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("D_clr", 32'(err_flags), 32'd0);

        // Frame E: short last line, extra line dropped, closed by pad
        vsync(1'b0, 1'b0, 1'b0);
        send_line(0, W, 1'b1);
        send_line(1, W, 1'b1);
        send_line(2, W, 1'b1);
        send_line(3, 5, 1'b1);
        chk("E_short_err", 32'(err_flags), 32'b100);
        send_line(0, W, 1'b0);
        chk("E_extra_err", 32'(err_flags), 32'b110);
        vsync(1'b1, 1'b0, 1'b0);
        chk("E_err", 32'(err_flags), 32'b111);
        chk("E_fc",  32'(frame_cnt), 32'(exp_fc));
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;

        // Empty frame: pad carries start as well; tpg_sel sampled here
        tpg_sel = 1'b1;
        vsync(1'b1, 1'b1, 1'b0);
        tpg_sel = 1'b0;
        chk("empty_err", 32'(err_flags), 32'b001);
        chk("empty_fc",  32'(frame_cnt), 32'(exp_fc));

        // Pattern frame, rgb forced to all ones
        tpg_mode = 1'b1;
        clean_frame_lines();
        tpg_mode = 1'b0;
        chk("tpg_fc", 32'(frame_cnt), 32'(exp_fc));

        // Reset in the middle of line 2
        vsync(1'b0, 1'b0, 1'b0);
        send_line(0, W, 1'b1);
        send_line(1, W, 1'b1);
        for (int x = 0; x < 3; x++) begin
            @(negedge clk);
            de = 1'b1; rgb = pix(x, 2);
            push_beat(pix(x, 2), 1'b0, 1'b0);
        end
        @(negedge clk);
        de = 1'b1; rgb = pix(3, 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(dst_valid), 32'd0);
        chk("mid_rst_last",  32'(dst_last),  32'd0);
        chk("mid_rst_data",  32'(dst_data),  32'd0);
        chk("mid_rst_fc",    32'(frame_cnt), 32'd0);
        chk("mid_rst_err",   32'(err_flags), 32'd0);
        @(negedge clk);
        de = 1'b0;
        rst_n = 1'b1;
        exp_fc = 0;
        send_line(2, W, 1'b0);
        chk("post_rst_err", 32'(err_flags), 32'd0);
        chk("post_rst_fc",  32'(frame_cnt), 32'd0);
        vsync(1'b0, 1'b0, 1'b0);
        clean_frame_lines();
        chk("post_rst_frame_fc",  32'(frame_cnt), 32'(exp_fc));
        chk("post_rst_frame_err", 32'(err_flags), 32'd0);

        idle(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
